// File: rtl/entity_span_renderer_pkg.sv
// Shared constants and types for the entity span renderer.
// Optional feature: ENTITY_OUTLINE_EN adds a per-span y-edge bit and outline colouring.
package entity_span_renderer_pkg;

   localparam int ENT_SIZE  = 48;
   localparam int MAX_SPANS = 24;
   localparam int BOARD_PX  = 480;
   localparam int CNT_W     = $clog2(MAX_SPANS + 1);

   // Entity word layout {code[2:0], y[8:0], x[8:0]}
   localparam int X_LSB    = 0;
   localparam int Y_LSB    = 9;
   localparam int CODE_LSB = 18;

   localparam logic [2:0] CODE_BG      = 3'b000;
   localparam logic [2:0] CODE_OUTLINE = 3'b111;

   typedef struct packed {
      logic [2:0] code;
      logic [8:0] x;
`ifdef ENTITY_OUTLINE_EN
      logic       yedge;
`endif
   } span_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_FLUSH
   } state_t;

endpackage

// File: rtl/entity_span_renderer_span_table.sv
// Append-only span table: entries are written in arrival order and read all at once.
// Appends beyond MAX_SPANS are ignored; full tells the caller to flag overflow.
module entity_span_renderer_span_table
   import entity_span_renderer_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          append,
   input  span_t                         din,
   output span_t [MAX_SPANS-1:0]         entries,
   output logic  [CNT_W-1:0]             count,
   output logic                          full
);

   assign full = (count == CNT_W'(MAX_SPANS));

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (append && !full) begin
         count <= count + CNT_W'(1);
      end
   end

   // NOTE: entries are deliberately not reset; count gates every read, so stale data is never visible.
   always_ff @(posedge clk) begin
      for (int i = 0; i < MAX_SPANS; i++) begin
         if (append && !full && count == CNT_W'(i)) begin
            entries[i] <= din;
         end
      end
   end

endmodule

// File: rtl/entity_span_renderer.sv
// Scans the entity RAM once per display line into a ping-pong span table and resolves pixel colour codes.
// Optional feature: ENTITY_OUTLINE_EN draws square edges with the outline code.
module entity_span_renderer
   import entity_span_renderer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        line_start,
   input  logic [8:0]  line_y,
   input  logic [7:0]  entities_number,
   output logic [7:0]  ent_addr,
   input  logic [20:0] ent_data,
   input  logic        pixel_active,
   input  logic [9:0]  pixel_x,
   output logic [2:0]  pixel_code,
   output logic        busy,
   output logic        span_overflow,
   output logic        scan_late
);

   state_t     state;
   logic       sel;        // 0: table A displayed, B built; 1: the reverse
   logic [8:0] ly;
   logic [7:0] n_lat;
   logic       rd_valid;

   logic [2:0] w_code;
   logic [8:0] w_y;
   logic [8:0] w_x;
   logic [8:0] dy;
   logic       hit;
   span_t      new_span;

   span_t [MAX_SPANS-1:0] entries_a, entries_b, entries_d;
   logic  [CNT_W-1:0]     count_a, count_b, count_d;
   logic                  full_a, full_b, build_full;

   assign w_code = ent_data[CODE_LSB +: 3];
   assign w_y    = ent_data[Y_LSB +: 9];
   assign w_x    = ent_data[X_LSB +: 9];

   // 9-bit wrap lets squares shifted above line 0 still cover the top lines.
   assign dy  = ly - w_y;
   assign hit = rd_valid && !line_start && (w_code != CODE_BG) && (dy < 9'(ENT_SIZE));

   always_comb begin
      new_span      = '0;
      new_span.code = w_code;
      new_span.x    = w_x;
`ifdef ENTITY_OUTLINE_EN
      new_span.yedge = (dy == 9'd0) || (dy == 9'(ENT_SIZE - 1));
`endif
   end

   entity_span_renderer_span_table u_table_a (
      .clk     (clk),
      .reset   (reset),
      .clear   (line_start && !sel),
      .append  (hit && sel),
      .din     (new_span),
      .entries (entries_a),
      .count   (count_a),
      .full    (full_a)
   );

   entity_span_renderer_span_table u_table_b (
      .clk     (clk),
      .reset   (reset),
      .clear   (line_start && sel),
      .append  (hit && !sel),
      .din     (new_span),
      .entries (entries_b),
      .count   (count_b),
      .full    (full_b)
   );

   assign build_full = sel ? full_a : full_b;
   assign entries_d  = sel ? entries_b : entries_a;
   assign count_d    = sel ? count_b : count_a;

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         ent_addr      <= '0;
         busy          <= 1'b0;
         sel           <= 1'b0;
         ly            <= '0;
         n_lat         <= '0;
         rd_valid      <= 1'b0;
         span_overflow <= 1'b0;
         scan_late     <= 1'b0;
      end else begin
         if (hit && build_full) begin
            span_overflow <= 1'b1;
         end
         // A read issued in the same cycle as line_start belongs to the aborted scan.
         rd_valid <= (state == ST_SCAN) && !line_start;
         if (line_start) begin
            if (busy) begin
               scan_late <= 1'b1;
            end
            sel      <= ~sel;
            ly       <= line_y;
            n_lat    <= entities_number;
            ent_addr <= '0;
            if (entities_number == 8'd0) begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end else begin
               state <= ST_SCAN;
               busy  <= 1'b1;
            end
         end else begin
            case (state)
               ST_SCAN: begin
                  if (ent_addr == n_lat - 8'd1) begin
                     state <= ST_FLUSH;
                  end else begin
                     ent_addr <= ent_addr + 8'd1;
                  end
               end
               ST_FLUSH: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   logic [2:0] code_next;
   logic [9:0] dx;

   // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
   always_comb begin
      code_next = CODE_BG;
      dx        = '0;
      // Ascending scan: the highest-index hit overwrites earlier ones and wins.
      for (int i = 0; i < MAX_SPANS; i++) begin
         dx = pixel_x - {1'b0, entries_d[i].x};
         if (CNT_W'(i) < count_d && dx < 10'(ENT_SIZE)) begin
            code_next = entries_d[i].code;
`ifdef ENTITY_OUTLINE_EN
            if (dx == 10'd0 || dx == 10'(ENT_SIZE - 1) || entries_d[i].yedge) begin
               code_next = CODE_OUTLINE;
            end
`endif
         end
      end
      if (!pixel_active || pixel_x >= 10'(BOARD_PX)) begin
         code_next = CODE_BG;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pixel_code <= CODE_BG;
      end else begin
         pixel_code <= code_next;
      end
   end

endmodule

// File: tb/tb_entity_span_renderer.sv
// Self-checking bench for entity_span_renderer: directed tables, multi-cycle corner sequences
// and randomized lines checked against a queue-based span model.
module tb_entity_span_renderer;

   localparam int ESZ   = 48;
   localparam int NSPAN = 24;
   localparam int BPX   = 480;
`ifdef ENTITY_OUTLINE_EN
   localparam int EC = 7;
`else
   localparam int EC = 1;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        line_start;
   logic [8:0]  line_y;
   logic [7:0]  entities_number;
   logic [7:0]  ent_addr;
   logic [20:0] ent_data;
   logic        pixel_active;
   logic [9:0]  pixel_x;
   logic [2:0]  pixel_code;
   logic        busy;
   logic        span_overflow;
   logic        scan_late;

   entity_span_renderer dut (
      .clk             (clk),
      .reset           (reset),
      .line_start      (line_start),
      .line_y          (line_y),
      .entities_number (entities_number),
      .ent_addr        (ent_addr),
      .ent_data        (ent_data),
      .pixel_active    (pixel_active),
      .pixel_x         (pixel_x),
      .pixel_code      (pixel_code),
      .busy            (busy),
      .span_overflow   (span_overflow),
      .scan_late       (scan_late)
   );

   always #5 clk = ~clk;

   // Entity RAM with one-cycle read latency
   logic [20:0] ram [256];
   always @(posedge clk) ent_data <= ram[ent_addr];

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: span lists as queues, built from the hit rules with plain integer arithmetic.
   typedef struct {
      int code;
      int x;
      bit yedge;
   } mspan_t;

   mspan_t disp_q[$];
   mspan_t build_q[$];
   bit     model_ovf = 1'b0;

   function automatic logic [20:0] word(input int c, input int y, input int x);
      return {c[2:0], y[8:0], x[8:0]};
   endfunction

   task automatic clear_ram();
      foreach (ram[i]) ram[i] = '0;
   endtask

   // limit = number of addresses the scan is expected to have evaluated before being cut short
   task automatic model_build(input int ly, input int n, input int limit);
      build_q.delete();
      for (int a = 0; a < n && a < limit; a++) begin
         int c;
         int y;
         int x;
         int dyv;
         c   = int'(ram[a][20:18]);
         y   = int'(ram[a][17:9]);
         x   = int'(ram[a][8:0]);
         dyv = (ly - y + 512) % 512;
         if (c != 0 && dyv < ESZ) begin
            if (build_q.size() < NSPAN) build_q.push_back('{c, x, (dyv == 0 || dyv == ESZ - 1)});
            else model_ovf = 1'b1;
         end
      end
   endtask

   function automatic int exp_pixel(input int px, input bit act);
      int r;
      r = 0;
      if (!act || px >= BPX) return 0;
      foreach (disp_q[i]) begin
         int dxv;
         dxv = (px - disp_q[i].x + 1024) % 1024;
         if (dxv < ESZ) begin
            r = disp_q[i].code;
`ifdef ENTITY_OUTLINE_EN
            if (dxv == 0 || dxv == ESZ - 1 || disp_q[i].yedge) r = 7;
`endif
         end
      end
      return r;
   endfunction

   // All drive tasks start and end on a falling edge.
   task automatic line_pulse(input int ly, input int n, input int limit);
      line_y          = 9'(ly);
      entities_number = 8'(n);
      line_start      = 1'b1;
      disp_q = build_q;
      model_build(ly, n, limit);
      @(negedge clk);
      line_start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string name);
      int k;
      k = 0;
      while (busy && k < budget) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(busy), 0);
   endtask

   task automatic show(input int ly, input int n);
      line_pulse(ly, n, 256);
      wait_idle(300, "scan_done");
      line_pulse(0, 0, 256);
   endtask

   task automatic pix(input int px, input bit act, input string name);
      pixel_x      = 10'(px);
      pixel_active = act;
      @(negedge clk);
      check(name, 32'(pixel_code), 32'(exp_pixel(px, act)));
   endtask

   typedef struct {
      int px;
      bit act;
      int exp;
   } vec_t;

   vec_t tbl[11];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl = '{'{95, 1, 0}, '{96, 1, EC}, '{97, 1, 1}, '{120, 1, 1}, '{142, 1, 1},
              '{143, 1, EC}, '{144, 1, 0}, '{120, 0, 0}, '{0, 1, 0}, '{479, 1, 0}, '{600, 1, 0}};

      reset = 1'b1;
      line_start = 1'b0;
      line_y = '0;
      entities_number = '0;
      pixel_active = 1'b0;
      pixel_x = '0;
      clear_ram();
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_pixel", 32'(pixel_code), 0);
      check("rst_addr", 32'(ent_addr), 0);
      check("rst_ovf", 32'(span_overflow), 0);
      check("rst_late", 32'(scan_late), 0);
      reset = 1'b0;
      @(negedge clk);

      // Single entity, table-driven
      ram[0] = word(1, 48, 96);
      show(50, 1);
      foreach (tbl[i]) begin
         pixel_x      = 10'(tbl[i].px);
         pixel_active = tbl[i].act;
         @(negedge clk);
         check($sformatf("single_px%0d", tbl[i].px), 32'(pixel_code), 32'(tbl[i].exp));
      end
      // One-cycle latency: output still shows the previous pixel before the clock edge
      pixel_x = 10'd120;
      pixel_active = 1'b1;
      #1 check("latency_hold", 32'(pixel_code), 0);
      @(negedge clk);
      check("latency_update", 32'(pixel_code), 1);

      // Vertical wrap
      clear_ram();
      ram[0] = word(3, 500, 0);
      show(20, 1);
      check("wrap_hit_mid", 32'(pixel_code), 0);
      pix(24, 1, "wrap_hit_24");
      foreach (tbl[i]) pix(tbl[i].px % 60, 1, "wrap_hit");
      show(36, 1);
      pix(24, 1, "wrap_miss");

      // Overlap: later address draws on top
      clear_ram();
      ram[5]   = word(1, 0, 0);
      ram[100] = word(2, 0, 24);
      show(10, 101);
      foreach (tbl[i]) pix(tbl[i].px % 80, 1, "overlap");

      // Overflow: 30 hits, only the first 24 kept
      clear_ram();
      for (int i = 0; i < 30; i++) ram[i] = word(1 + i % 7, 200, i * 17);
      show(210, 30);
      check("ovf_set", 32'(span_overflow), 1);
      for (int i = 0; i < 30; i++) pix(i * 17 + 8, 1, "ovf_px");
      show(300, 1);
      check("ovf_sticky", 32'(span_overflow), 1);

      // Randomized lines against the model
      for (int t = 0; t < 8; t++) begin
         int ly;
         int n;
         ly = int'($urandom_range(0, 511));
         n  = int'($urandom_range(1, 40));
         clear_ram();
         for (int a = 0; a < n; a++)
            ram[a] = word(int'($urandom_range(0, 7)), (ly - int'($urandom_range(0, 70)) + 512) % 512,
                          int'($urandom_range(0, 511)));
         show(ly, n);
         check("rand_ovf", 32'(span_overflow), 32'(model_ovf));
         for (int p = 0; p < 30; p++)
            pix(int'($urandom_range(0, 520)), ($urandom_range(0, 7) != 0), "rand_px");
      end

      // Zero entities: no scan, built table stays empty
      line_pulse(5, 0, 256);
      check("n0_idle", 32'(busy), 0);
      line_pulse(0, 0, 256);
      pix(10, 1, "n0_empty");

      // Late line_start: abort and display the partial table
      check("late_before", 32'(scan_late), 0);
      clear_ram();
      ram[10]  = word(2, 100, 0);
      ram[150] = word(4, 100, 200);
      // Any cut-off between addresses 11 and 150 yields the same partial table.
      line_pulse(110, 200, 100);
      repeat (98) @(negedge clk);
      line_pulse(110, 200, 100);
      check("late_flag", 32'(scan_late), 1);
      pix(20, 1, "late_partial_in");
      pix(210, 1, "late_partial_out");
      repeat (95) @(negedge clk);
      line_pulse(110, 200, 256);
      wait_idle(400, "late_no_hang");
      line_pulse(0, 0, 256);
      pix(210, 1, "late_full_150");
      pix(20, 1, "late_full_10");
      check("late_sticky", 32'(scan_late), 1);

      // Reset in the middle of a scan
      line_pulse(110, 200, 256);
      repeat (20) @(negedge clk);
      pixel_x = 10'd20;
      pixel_active = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_busy", 32'(busy), 0);
      check("mid_rst_pixel", 32'(pixel_code), 0);
      check("mid_rst_addr", 32'(ent_addr), 0);
      check("mid_rst_late", 32'(scan_late), 0);
      check("mid_rst_ovf", 32'(span_overflow), 0);
      reset = 1'b0;
      disp_q.delete();
      build_q.delete();
      model_ovf = 1'b0;
      clear_ram();
      ram[1] = word(6, 110, 0);
      line_pulse(110, 3, 256);
      check("post_rst_addr0", 32'(ent_addr), 0);
      check("post_rst_busy", 32'(busy), 1);
      @(negedge clk);
      check("post_rst_addr1", 32'(ent_addr), 1);
      wait_idle(50, "post_rst_done");
      pix(20, 1, "post_rst_empty");
      line_pulse(0, 0, 256);
      pix(20, 1, "post_rst_drawn");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
